// File: rtl/midi_note_parser.sv
// midi_note_parser
//  Parses the UART_RX byte stream into MIDI Note-On / Note-Off events.
//  All other channel messages, system common and SysEx traffic are skipped;
//  realtime bytes (0xF8..0xFF) are invisible to the parser.
//  Optional feature macro: MIDI_RUNNING_STATUS_EN (running status for 0x8n/0x9n).
// Ports
//  i_Clock       system clock, rising edge
//  i_Rst         asynchronous reset, active-high
//  i_RX_DV       1-cycle strobe, i_RX_Byte valid
//  i_RX_Invalid  1-cycle strobe, framing error on last byte
//  i_RX_Byte     received byte
//  o_Note_Valid  1-cycle strobe, note outputs updated this cycle
//  o_Note_On     1 = note on, 0 = note off (0x9n with velocity 0 reports off)
//  o_Note_Num    MIDI note number
//  o_Velocity    raw velocity byte
//  o_Channel     channel of the emitted message
//  o_Err         1-cycle strobe, framing error or inter-byte timeout
module midi_note_parser #(
   parameter int unsigned C_CLK_FRQ    = 100_000_000,
   parameter int unsigned C_TIMEOUT_US = 1000,
   parameter int unsigned C_CHANNEL    = 0,
   parameter int unsigned C_OMNI       = 0
) (
   input  logic       i_Clock,
   input  logic       i_Rst,
   input  logic       i_RX_DV,
   input  logic       i_RX_Invalid,
   input  logic [7:0] i_RX_Byte,
   output logic       o_Note_Valid,
   output logic       o_Note_On,
   output logic [6:0] o_Note_Num,
   output logic [6:0] o_Velocity,
   output logic [3:0] o_Channel,
   output logic       o_Err
);

   localparam int unsigned C_TMO_CLKS = (C_CLK_FRQ / 1_000_000) * C_TIMEOUT_US;
   localparam bit          C_TMO_EN   = (C_TMO_CLKS != 0);
   localparam int unsigned C_TMO_W    = (C_TMO_CLKS > 1) ? $clog2(C_TMO_CLKS) : 1;
   localparam int unsigned C_TMO_LAST = C_TMO_EN ? (C_TMO_CLKS - 1) : 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DATA1 = 3'd1,
      S_DATA2 = 3'd2,
      S_SKIP  = 3'd3,
      S_SYSEX = 3'd4
   } state_t;

   state_t             state_q, state_n;
   logic [1:0]         skip_q, skip_n;
   logic [C_TMO_W-1:0] tmo_q;
   logic               status_on_q;
   logic [3:0]         status_ch_q;
   logic [6:0]         note_q;
   logic               rs_valid_q;

   logic       byte_dv_c, is_status_c, timed_st_c, tmo_c, chan_ok_c, rs_ok_c;
   logic       load_status_c, load_note_c, emit_c, err_c, rs_clr_c;
   logic [3:0] nib_c;

   // Realtime bytes and bytes hit by a framing error are not parser input
   assign byte_dv_c   = i_RX_DV && !i_RX_Invalid && (i_RX_Byte[7:3] != 5'b11111);
   assign is_status_c = i_RX_Byte[7];
   assign nib_c       = i_RX_Byte[7:4];
   assign timed_st_c  = (state_q == S_DATA1) || (state_q == S_DATA2) || (state_q == S_SKIP);
   assign tmo_c       = C_TMO_EN && timed_st_c && !i_RX_Invalid && !byte_dv_c &&
                        (tmo_q == C_TMO_W'(C_TMO_LAST));
   assign chan_ok_c   = (C_OMNI != 0) || (status_ch_q == 4'(C_CHANNEL));
`ifdef MIDI_RUNNING_STATUS_EN
   assign rs_ok_c     = rs_valid_q;
`else
   assign rs_ok_c     = 1'b0;
`endif

   // State register
   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst) begin
         state_q <= S_IDLE;
         skip_q  <= 2'd0;
      end else begin
         state_q <= state_n;
         skip_q  <= skip_n;
      end
   end

   // Next-state decode; a status byte restarts decoding from any state
   always_comb begin
      state_n = state_q;
      skip_n  = skip_q;
      if (i_RX_Invalid || tmo_c) begin
         state_n = S_IDLE;
      end else if (byte_dv_c && is_status_c) begin
         case (nib_c)
            4'h8, 4'h9: state_n = S_DATA1;
            4'hC, 4'hD: begin state_n = S_SKIP; skip_n = 2'd1; end
            4'hA, 4'hB, 4'hE: begin state_n = S_SKIP; skip_n = 2'd2; end
            default:    state_n = (i_RX_Byte == 8'hF0) ? S_SYSEX : S_IDLE;
         endcase
      end else if (byte_dv_c) begin
         case (state_q)
            S_IDLE:  state_n = rs_ok_c ? S_DATA2 : S_IDLE;
            S_DATA1: state_n = S_DATA2;
`ifdef MIDI_RUNNING_STATUS_EN
            S_DATA2: state_n = S_DATA1;
`else
            S_DATA2: state_n = S_IDLE;
`endif
            S_SKIP: begin
               skip_n  = skip_q - 2'd1;
               state_n = (skip_q <= 2'd1) ? S_IDLE : S_SKIP;
            end
            default: state_n = state_q;
         endcase
      end
   end

   // Datapath strobes derived from current state and input byte
   always_comb begin
      load_status_c = 1'b0;
      load_note_c   = 1'b0;
      emit_c        = 1'b0;
      err_c         = i_RX_Invalid || tmo_c;
      rs_clr_c      = i_RX_Invalid || tmo_c;
      if (byte_dv_c && is_status_c) begin
         load_status_c = (nib_c == 4'h8) || (nib_c == 4'h9);
         rs_clr_c      = !load_status_c;
      end else if (byte_dv_c) begin
         load_note_c = (state_q == S_DATA1) || ((state_q == S_IDLE) && rs_ok_c);
         emit_c      = (state_q == S_DATA2) && chan_ok_c;
      end
   end

   // Inter-byte timeout counter; idle outside the message-body states
   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst)
         tmo_q <= '0;
      else if (byte_dv_c || !timed_st_c || i_RX_Invalid || tmo_c || !C_TMO_EN)
         tmo_q <= '0;
      else
         tmo_q <= tmo_q + C_TMO_W'(1);
   end

   // Message latches and registered outputs
   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst) begin
         status_on_q  <= 1'b0;
         status_ch_q  <= 4'd0;
         note_q       <= 7'd0;
         rs_valid_q   <= 1'b0;
         o_Note_Valid <= 1'b0;
         o_Note_On    <= 1'b0;
         o_Note_Num   <= 7'd0;
         o_Velocity   <= 7'd0;
         o_Channel    <= 4'd0;
         o_Err        <= 1'b0;
      end else begin
         o_Note_Valid <= emit_c;
         o_Err        <= err_c;
         if (load_status_c) begin
            status_on_q <= i_RX_Byte[4];
            status_ch_q <= i_RX_Byte[3:0];
            rs_valid_q  <= 1'b1;
         end else if (rs_clr_c) begin
            rs_valid_q  <= 1'b0;
         end
         if (load_note_c)
            note_q <= i_RX_Byte[6:0];
         if (emit_c) begin
            o_Note_On  <= status_on_q && (i_RX_Byte[6:0] != 7'd0);
            o_Note_Num <= note_q;
            o_Velocity <= i_RX_Byte[6:0];
            o_Channel  <= status_ch_q;
         end
      end
   end

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench for midi_note_parser: 20-clock timeout, channel 0, omni off.
module tb_midi_note_parser;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_dv, rx_inv;
   logic [7:0] rx_byte;
   logic       note_valid, note_on, err;
   logic [6:0] note_num, vel;
   logic [3:0] chan;

   typedef struct packed {
      logic       on;
      logic [6:0] num;
      logic [6:0] vel;
      logic [3:0] ch;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  err_seen = 0;
   int  exp_err = 0;

   midi_note_parser #(
      .C_CLK_FRQ(1_000_000), .C_TIMEOUT_US(20), .C_CHANNEL(0), .C_OMNI(0)
   ) dut (
      .i_Clock(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Invalid(rx_inv),
      .i_RX_Byte(rx_byte), .o_Note_Valid(note_valid), .o_Note_On(note_on),
      .o_Note_Num(note_num), .o_Velocity(vel), .o_Channel(chan), .o_Err(err)
   );

   always #5 clk = ~clk;

   // Monitor: pop expected event whenever the DUT emits one
   always @(negedge clk) begin
      if (!rst) begin
         if (err) err_seen++;
         if (note_valid) begin
            ev_t got, exp;
            got = {note_on, note_num, vel, chan};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL event: unexpected event got on=%0d num=%h vel=%h ch=%h",
                        note_on, note_num, vel, chan);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL event: got on=%0d num=%h vel=%h ch=%h, want on=%0d num=%h vel=%h ch=%h",
                           got.on, got.num, got.vel, got.ch, exp.on, exp.num, exp.vel, exp.ch);
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_dv = 1'b1; rx_byte = b;
      @(negedge clk);
      rx_dv = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_invalid(input logic with_dv, input logic [7:0] b);
      @(negedge clk);
      rx_inv = 1'b1; rx_dv = with_dv; rx_byte = b;
      @(negedge clk);
      rx_inv = 1'b0; rx_dv = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic expect_ev(input logic on, input logic [6:0] num, input logic [6:0] v,
                            input logic [3:0] ch);
      exp_q.push_back({on, num, v, ch});
   endtask

   // End-of-scenario check: all expected events seen, error pulse count matches
   task automatic checkpoint(input string name);
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected events missing", name, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (err_seen != exp_err) begin
         errors++;
         $display("FAIL %s err pulses: got %0d want %0d", name, err_seen, exp_err);
         err_seen = exp_err;
      end
   endtask

   initial begin
      rst = 1'b1; rx_dv = 1'b0; rx_inv = 1'b0; rx_byte = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({note_valid, note_on, note_num, vel, chan, err} !== 21'd0) begin
         errors++;
         $display("FAIL reset: outputs got %h want 0",
                  {note_valid, note_on, note_num, vel, chan, err});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic note on
      expect_ev(1'b1, 7'h3C, 7'h64, 4'h0);
      send(8'h90); send(8'h3C); send(8'h64);
      checkpoint("note_on");

      // Note off, and note on with velocity 0 reported as off
      expect_ev(1'b0, 7'h3C, 7'h40, 4'h0);
      expect_ev(1'b0, 7'h3C, 7'h00, 4'h0);
      send(8'h80); send(8'h3C); send(8'h40);
      send(8'h90); send(8'h3C); send(8'h00);
      checkpoint("note_off");

      // Running status
      expect_ev(1'b1, 7'h40, 7'h50, 4'h0);
`ifdef MIDI_RUNNING_STATUS_EN
      expect_ev(1'b1, 7'h41, 7'h51, 4'h0);
`endif
      send(8'h90); send(8'h40); send(8'h50); send(8'h41); send(8'h51);
      checkpoint("running_status");

      // Realtime bytes interleaved
      expect_ev(1'b1, 7'h3C, 7'h64, 4'h0);
      send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
      checkpoint("realtime");

      // Framing error mid-message, then normal message
      send(8'h90); send(8'h3C);
      send_invalid(1'b0, 8'h00);
      exp_err++;
      send(8'h64);
      checkpoint("invalid_abort");
      expect_ev(1'b1, 7'h3C, 7'h64, 4'h0);
      send(8'h90); send(8'h3C); send(8'h64);
      checkpoint("after_invalid");

      // Invalid coinciding with the velocity byte discards it
      send(8'h90); send(8'h3C);
      send_invalid(1'b1, 8'h64);
      exp_err++;
      checkpoint("invalid_with_dv");

      // Inter-byte timeout
      send(8'h90); send(8'h3C);
      repeat (40) @(negedge clk);
      exp_err++;
      send(8'h64);
      checkpoint("timeout");

      // SysEx never times out; status aborts it
      send(8'hF0); send(8'h3C);
      repeat (40) @(negedge clk);
      send(8'h64); send(8'hF7); send(8'h3C); send(8'h64);
      checkpoint("sysex");

      // Other channel filtered
      send(8'h91); send(8'h3C); send(8'h64);
      checkpoint("channel_filter");

      // Control change skips two data bytes; following data dropped
      send(8'hB0); send(8'h07); send(8'h64); send(8'h3C); send(8'h50);
      checkpoint("skip_cc");

      // Program change skips one byte, then a note
      expect_ev(1'b1, 7'h3C, 7'h64, 4'h0);
      send(8'hC0); send(8'h05); send(8'h90); send(8'h3C); send(8'h64);
      checkpoint("skip_pc");

      // Status byte aborts pending message
      expect_ev(1'b0, 7'h3D, 7'h20, 4'h0);
      send(8'h90); send(8'h3C); send(8'h80); send(8'h3D); send(8'h20);
      checkpoint("status_abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
